// File: rtl/jt89_pkg.sv
// Shared definitions for the SN76489-family noise channel: attenuation
// table, rate selector encoding and the LFSR seed helper.
package jt89_pkg;

    localparam int MAX_LFSR_W = 32;

    typedef enum logic [1:0] {
        RATE_D1    = 2'd0,
        RATE_D2    = 2'd1,
        RATE_D4    = 2'd2,
        RATE_TONE2 = 2'd3
    } rate_e;

    // Roughly 2 dB per step, full scale 255, index 15 mutes the channel.
    localparam logic [8:0] ATT_TBL [16] = '{
        9'd255, 9'd203, 9'd161, 9'd128, 9'd102, 9'd81, 9'd64, 9'd51,
        9'd40,  9'd32,  9'd26,  9'd20,  9'd16,  9'd13, 9'd10, 9'd0
    };

    // Seed value: only the most significant LFSR bit set.
    function automatic logic [MAX_LFSR_W-1:0] lfsr_seed(input int width);
        return {{(MAX_LFSR_W-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

// File: rtl/jt89_lfsr.sv
// Noise shift register: right-shifting LFSR with white/periodic feedback,
// seed load on control writes and recovery from the all-zero lock-up state.
module jt89_lfsr
    import jt89_pkg::*;
#(
    parameter int LFSR_W    = 16,
    parameter int WHITE_TAP = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic              white,
    output logic [LFSR_W-1:0] lfsr
);

    localparam logic [LFSR_W-1:0] SEED = LFSR_W'(lfsr_seed(LFSR_W));

    logic fb;

    // Feedback bit: tap XOR in white mode, plain rotation in periodic mode.
    always_comb begin
        fb = white ? (lfsr[0] ^ lfsr[WHITE_TAP]) : lfsr[0];
    end

    // Register update; a load beats a coincident advance so the new mode starts from the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (load) begin
            lfsr <= SEED;
        end else if (adv) begin
            if (lfsr == '0) begin
                lfsr <= SEED;
            end else begin
                lfsr <= {fb, lfsr[LFSR_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/jt89_noise_gen.sv
// SN76489-family noise channel: control register, rate/period counter,
// LFSR instance and attenuated amplitude output for the PSG mixer.
module jt89_noise_gen
    import jt89_pkg::*;
#(
    parameter int LFSR_W    = 16,
    parameter int WHITE_TAP = 3,
    parameter int DIV_BASE  = 32,
    parameter int CNT_W     = 11,
    parameter int TONE_SYNC = 0,
    parameter int OUT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             ctrl_we,
    input  logic [2:0]       ctrl_din,
    input  logic [3:0]       vol,
    input  logic [9:0]       tone2,
    input  logic             tone2_tick,
    output logic             noise_bit,
    output logic             shift_tick,
    output logic [OUT_W-1:0] snd
);

    logic [2:0]        ctrl;
    rate_e             rate;
    logic              white;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period;
    logic              tone_sync_mode;
    logic              adv;
    logic [LFSR_W-1:0] lfsr;

    assign rate      = rate_e'(ctrl[1:0]);
    assign white     = ctrl[2];
    assign noise_bit = lfsr[0];

    // Reload value for the period counter, sampled only at reload time.
    always_comb begin
        period = CNT_W'(DIV_BASE);
        case (rate)
            RATE_D1:    period = CNT_W'(DIV_BASE);
            RATE_D2:    period = CNT_W'(2 * DIV_BASE);
            RATE_D4:    period = CNT_W'(4 * DIV_BASE);
            RATE_TONE2: period = (tone2 == 10'd0) ? CNT_W'(2) : CNT_W'({tone2, 1'b0});
            default:    period = CNT_W'(DIV_BASE);
        endcase
    end

    // Advance source: tone 2 toggle pulses in sync mode, otherwise counter expiry.
    always_comb begin
        tone_sync_mode = (TONE_SYNC != 0) && (rate == RATE_TONE2);
        if (tone_sync_mode) begin
            adv = clk_en & tone2_tick;
        end else begin
            adv = clk_en & (cnt == CNT_W'(1));
        end
    end

    // Control register; reset takes priority over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= 3'b000;
        end else if (ctrl_we) begin
            ctrl <= ctrl_din;
        end
    end

    // Period counter; frozen while tracking tone 2 ticks directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clk_en && !tone_sync_mode) begin
            if (cnt <= CNT_W'(1)) begin
                cnt <= period;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // One-clock pulse marking each LFSR advance, even one overridden by a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_tick <= 1'b0;
        end else begin
            shift_tick <= adv;
        end
    end

    // Attenuated amplitude, scaled to the output width, updated at the PSG rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            snd <= '0;
        end else if (clk_en) begin
            snd <= lfsr[0] ? (OUT_W'(ATT_TBL[vol]) << (OUT_W - 9)) : '0;
        end
    end

    jt89_lfsr #(
        .LFSR_W    (LFSR_W),
        .WHITE_TAP (WHITE_TAP)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (ctrl_we),
        .adv   (adv),
        .white (white),
        .lfsr  (lfsr)
    );

endmodule
